result_tx_serializer: RTL

//   Sits between the matrix Calculator and uart_tx. Captures the 144-bit product
//   (9 x 16-bit elements) on mult_done and streams it as 18 bytes.

---
 rtl/matmul_pkg.sv | 34 +++
 rtl/result_byte_mux.sv | 28 ++
 rtl/result_tx_serializer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and byte-lane helper for the result serializer.
// SERIALIZER_CHECKSUM_EN adds a trailing checksum byte to every frame.
package matmul_pkg;

  localparam int MAT_ELEMS      = 9;
  localparam int ELEM_W         = 16;
  localparam int BYTE_W         = 8;
  localparam int RESULT_W       = MAT_ELEMS * ELEM_W;
  localparam int BYTES_PER_ELEM = ELEM_W / BYTE_W;
  localparam int DATA_BYTES     = MAT_ELEMS * BYTES_PER_ELEM;

`ifdef SERIALIZER_CHECKSUM_EN
  localparam int FRAME_BYTES = DATA_BYTES + 1;
`else
  localparam int FRAME_BYTES = DATA_BYTES;
`endif

  localparam int IDX_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_ACK,
    WAIT_DONE,
    DONE
  } ser_state_t;

  // Bit offset of frame byte k: element k/BYTES_PER_ELEM, most significant byte first.
  function automatic int byte_lsb(input int k);
    return (k / BYTES_PER_ELEM) * ELEM_W + (BYTES_PER_ELEM - 1 - (k % BYTES_PER_ELEM)) * BYTE_W;
  endfunction

endpackage

// File: rtl/result_byte_mux.sv
// Combinational selection of frame byte k from the captured product.
// With SERIALIZER_CHECKSUM_EN the index just past the data bytes selects the checksum.
module result_byte_mux
  import matmul_pkg::*;
(
  input  logic [RESULT_W-1:0] i_shadow,
  input  logic [IDX_W-1:0]    i_byte_idx,
`ifdef SERIALIZER_CHECKSUM_EN
  input  logic [BYTE_W-1:0]   i_checksum,
`endif
  output logic [BYTE_W-1:0]   o_byte
);

  always_comb begin
    o_byte = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (i_byte_idx == IDX_W'(k)) begin
        o_byte = i_shadow[byte_lsb(k) +: BYTE_W];
      end
    end
`ifdef SERIALIZER_CHECKSUM_EN
    if (i_byte_idx == IDX_W'(DATA_BYTES)) begin
      o_byte = i_checksum;
    end
`endif
  end

endmodule

// File: rtl/result_tx_serializer.sv
// Captures the 144-bit matrix product and streams it byte by byte through the uart_tx handshake.
// SERIALIZER_CHECKSUM_EN appends a mod-256 sum of the data bytes as a final byte.
module result_tx_serializer
  import matmul_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_result_valid,
  input  logic [RESULT_W-1:0] i_result,
  input  logic                i_tx_busy,
  output logic                o_tx_start,
  output logic [BYTE_W-1:0]   o_tx_data,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic                o_drop_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  ser_state_t          r_state;
  logic [RESULT_W-1:0] r_shadow;
  logic [IDX_W-1:0]    r_byte_idx;
  logic                r_tx_start;
  logic [BYTE_W-1:0]   r_tx_data;
  logic                r_busy;
  logic                r_frame_done;
  logic                r_drop_err;
  logic [BYTE_W-1:0]   w_byte;

`ifdef SERIALIZER_CHECKSUM_EN
  logic [BYTE_W-1:0]   r_checksum;
`endif

  result_byte_mux u_byte_mux (
    .i_shadow   (r_shadow),
    .i_byte_idx (r_byte_idx),
`ifdef SERIALIZER_CHECKSUM_EN
    .i_checksum (r_checksum),
`endif
    .o_byte     (w_byte)
  );

  // The shadow only loads in IDLE, so a frame in flight can never be corrupted by a new product.
  always_ff @(posedge i_clk) begin
    if (!i_rst && r_state == IDLE && i_result_valid) begin
      r_shadow <= i_result;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_byte_idx   <= '0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_drop_err   <= 1'b0;
`ifdef SERIALIZER_CHECKSUM_EN
      r_checksum   <= '0;
`endif
    end else begin
      r_tx_start   <= 1'b0;
      r_frame_done <= 1'b0;
      r_drop_err   <= i_result_valid && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (i_result_valid) begin
            r_byte_idx <= '0;
            r_busy     <= 1'b1;
            r_state    <= LOAD;
`ifdef SERIALIZER_CHECKSUM_EN
            r_checksum <= '0;
`endif
          end
        end
        LOAD: begin
          r_tx_data <= w_byte;
          if (!i_tx_busy) begin
            r_tx_start <= 1'b1;
            r_state    <= SEND;
`ifdef SERIALIZER_CHECKSUM_EN
            if (r_byte_idx < IDX_W'(DATA_BYTES)) begin
              r_checksum <= r_checksum + w_byte;
            end
`endif
          end
        end
        SEND: begin
          r_state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (i_tx_busy) begin
            r_state <= WAIT_DONE;
          end
        end
        // A byte is complete only once uart_tx drops busy again.
        WAIT_DONE: begin
          if (!i_tx_busy) begin
            if (r_byte_idx == LAST_IDX) begin
              r_state      <= DONE;
              r_busy       <= 1'b0;
              r_frame_done <= 1'b1;
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
              r_state    <= LOAD;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_tx_start   = r_tx_start;
  assign o_tx_data    = r_tx_data;
  assign o_busy       = r_busy;
  assign o_frame_done = r_frame_done;
  assign o_drop_err   = r_drop_err;

endmodule
